// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC generation, variable-latency imem port and prefetch FIFO.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     PC_INC    = 4,
  parameter int unsigned     PC_OFFSET = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redir_w_valid,
  input  logic [XLEN-1:0] redir_w_pc,
  input  logic            redir_e_valid,
  input  logic [XLEN-1:0] redir_e_pc,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_bubble,
`endif
  output logic            instr_valid_d,
  output logic [ILEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_plus8_d
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [ILEN-1:0] fifo_data [DEPTH];
  logic [XLEN-1:0] tag_q     [DEPTH];

  logic [AW-1:0] f_wr, f_rd, t_wr, t_rd;
  logic [CW-1:0] f_cnt, outstanding, stale, out_next;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            credit_ok, fire, rsp, drop, push, pop, f_empty;

  assign redirect = redir_e_valid | redir_w_valid;
  assign target   = redir_e_valid ? redir_e_pc : redir_w_pc;

  // FIFO slots plus in-flight requests never exceed DEPTH, so pushes can't overflow
  assign credit_ok = ({1'b0, f_cnt} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

  assign imem_req_valid = !reset && !stall_f && !redirect && credit_ok;
  assign imem_req_addr  = fetch_pc;

  assign fire    = imem_req_valid && imem_req_ready;
  assign rsp     = imem_rsp_valid && (outstanding != '0);
  assign drop    = rsp && ((stale != '0) || redirect);
  assign push    = rsp && !drop;
  assign f_empty = (f_cnt == '0);
  assign pop     = !stall_d && !flush_d && !f_empty && !redirect;

  always_comb begin
    out_next = outstanding;
    if (fire) out_next = out_next + CW'(1);
    if (rsp)  out_next = out_next - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      t_wr        <= '0;
      t_rd        <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      f_cnt       <= '0;
    end else begin
      outstanding <= out_next;
      if (fire) t_wr <= t_wr + AW'(1);
      if (rsp)  t_rd <= t_rd + AW'(1);
      if (redirect) begin
        fetch_pc <= target;
        stale    <= out_next;
        f_wr     <= '0;
        f_rd     <= '0;
        f_cnt    <= '0;
      end else begin
        if (fire) fetch_pc <= fetch_pc + XLEN'(PC_INC);
        if (rsp && (stale != '0)) stale <= stale - CW'(1);
        if (push) f_wr <= f_wr + AW'(1);
        if (pop)  f_rd <= f_rd + AW'(1);
        f_cnt <= f_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; pointers and counts define validity
  always_ff @(posedge clk) begin
    if (fire) tag_q[t_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[f_wr]   <= tag_q[t_rd];
      fifo_data[f_wr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid_d <= 1'b0;
      instr_d       <= '0;
      pc_plus8_d    <= '0;
    end else if (!stall_d) begin
      if (flush_d) begin
        instr_valid_d <= 1'b0;
      end else if (pop) begin
        instr_valid_d <= 1'b1;
        instr_d       <= fifo_data[f_rd];
        pc_plus8_d    <= fifo_pc[f_rd] + XLEN'(PC_OFFSET);
      end else begin
        instr_valid_d <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_bubble  <= '0;
    end else begin
      if (push && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (drop && (perf_dropped != '1))
        perf_dropped <= perf_dropped + 32'd1;
      if (!stall_d && !flush_d && f_empty && (perf_bubble != '1))
        perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit with an in-order latency memory.
// Directed phases push expected decode outputs; a monitor pops and compares.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redir_w_valid = 1'b0;
  logic [31:0] redir_w_pc = '0;
  logic        redir_e_valid = 1'b0;
  logic [31:0] redir_e_pc = '0;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus8_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_bubble;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .redir_w_valid (redir_w_valid),
    .redir_w_pc    (redir_w_pc),
    .redir_e_valid (redir_e_valid),
    .redir_e_pc    (redir_e_pc),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched  (perf_fetched),
    .perf_dropped  (perf_dropped),
    .perf_bubble   (perf_bubble),
`endif
    .instr_valid_d (instr_valid_d),
    .instr_d       (instr_d),
    .pc_plus8_d    (pc_plus8_d)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int budget = 0;

  logic        fire_q = 1'b0;
  logic [31:0] addr_q = '0;
  logic        stall_d_q = 1'b0;

  always @(posedge clk) begin
    fire_q    <= imem_req_valid && imem_req_ready;
    addr_q    <= imem_req_addr;
    stall_d_q <= stall_d;
  end

  // Monitor: a fresh decode value appears after any edge without stall_d
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid_d && !stall_d_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got instr %h pc8 %h, none expected",
                 instr_d, pc_plus8_d);
      end else begin
        e = exp_q.pop_front();
        if (instr_d !== e.instr || pc_plus8_d !== e.pc8) begin
          errors++;
          $display("FAIL decode: got instr %h pc8 %h, expected %h %h",
                   instr_d, pc_plus8_d, e.instr, e.pc8);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic set_budget(input int n);
    budget = n;
    imem_req_ready = (budget > 0);
  endtask

  // Advance one cycle and run the memory model at the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (reset) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (fire_q) begin
        pend.push_back('{addr_q, cyc + lat});
        if (budget > 0) budget--;
      end
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend[0].addr;
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
    imem_req_ready = (budget > 0);
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back('{a, a + 32'd8});
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_budget(0);
    pend.delete();
    imem_rsp_valid = 1'b0;
    tick();
    #1;
    check("rst_valid", 32'(instr_valid_d), 32'd0);
    check("rst_instr", instr_d, 32'd0);
    check("rst_pc8", pc_plus8_d, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    #1;
    reset = 1'b0;
    #1;
    check("rst_first_req", {31'd0, imem_req_valid}, 32'd1);
    check("rst_first_addr", imem_req_addr, 32'h0);
  endtask

  task automatic redirect_cycle(input logic e, input logic [31:0] epc,
                                input logic w, input logic [31:0] wpc);
    redir_e_valid = e;
    redir_e_pc    = epc;
    redir_w_valid = w;
    redir_w_pc    = wpc;
    #1;
    check("redir_blocks_req", 32'(imem_req_valid), 32'd0);
    tick();
    redir_e_valid = 1'b0;
    redir_w_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // zero-wait stream: first decode at cycle 3, then one per cycle
    lat = 1;
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    set_budget(3);
    for (int i = 1; i <= 5; i++) begin
      tick();
      #1;
      check($sformatf("latency_c%0d", i), 32'(instr_valid_d),
            (i >= 3) ? 32'd1 : 32'd0);
    end
    drain(10);

    // memory not ready for 6 cycles
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      check("hold_req", {imem_req_valid, instr_valid_d, imem_req_addr[29:0]},
            {1'b1, 1'b0, 30'h0});
    end
    for (int a = 0; a < 16; a += 4) push_exp(32'(a));
    set_budget(4);
    drain(20);

    // redirect with 4 requests in flight
    lat = 5;
    do_reset();
    for (int a = 0; a < 16; a += 4) push_exp(32'(a));
    set_budget(4);
    drain(30);
    set_budget(4);
    for (int i = 0; i < 4; i++) tick();
    #1;
    redirect_cycle(1'b1, 32'h100, 1'b0, 32'h0);
    check("credit_full", 32'(imem_req_valid), 32'd0);
    push_exp(32'h100);
    push_exp(32'h104);
    set_budget(2);
    drain(60);

    // E and W together: E wins; then W alone
    lat = 1;
    redirect_cycle(1'b1, 32'h200, 1'b1, 32'h300);
    check("e_prio_addr", imem_req_addr, 32'h200);
    push_exp(32'h200);
    push_exp(32'h204);
    set_budget(2);
    drain(20);
    redirect_cycle(1'b0, 32'h0, 1'b1, 32'h400);
    check("w_addr", imem_req_addr, 32'h400);
    push_exp(32'h400);
    set_budget(1);
    drain(20);

    // decode stall with FIFO filling, release, then flush pulse
    stall_d = 1'b1;
    for (int a = 32'h404; a <= 32'h420; a += 4) push_exp(32'(a));
    set_budget(8);
    for (int i = 0; i < 8; i++) tick();
    #1;
    check("stall_req_off", 32'(imem_req_valid), 32'd0);
    check("stall_hold_v", 32'(instr_valid_d), 32'd1);
    check("stall_hold_i", instr_d, 32'h400);
    check("stall_hold_p", pc_plus8_d, 32'h408);
    stall_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("release_stream", 32'(instr_valid_d), 32'd1);
    end
    flush_d = 1'b1;
    tick();
    flush_d = 1'b0;
    #1;
    check("flush_bubble", 32'(instr_valid_d), 32'd0);
    drain(40);

    // address wrap
    redirect_cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
    check("wrap_addr", imem_req_addr, 32'hFFFF_FFF8);
    exp_q.push_back('{32'hFFFF_FFF8, 32'h0000_0000});
    exp_q.push_back('{32'hFFFF_FFFC, 32'h0000_0004});
    exp_q.push_back('{32'h0000_0000, 32'h0000_0008});
    set_budget(3);
    drain(20);
    check("wrap_next_addr", imem_req_addr, 32'h4);

    // reset mid-stream
    redirect_cycle(1'b1, 32'h700, 1'b0, 32'h0);
    push_exp(32'h700);
    push_exp(32'h704);
    set_budget(10);
    drain(20);
    do_reset();
    push_exp(32'h0);
    set_budget(1);
    drain(20);
    for (int i = 0; i < 6; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
